// File: rtl/fc_output_accumulator_if.sv
// Beat/result bundle between the hidden-layer producer, the output FC accumulator
// and the downstream argmax stage.
`timescale 1ns/1ps
interface fc_output_accumulator_if #(
  parameter int IN_W  = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 30
);
  logic                clr;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_act;
  logic [10*IN_W-1:0]  w_bus;
  logic [10*B_W-1:0]   bias_bus;
  logic [10*ACC_W-1:0] layer_out;
  logic                valid;

  // A beat transfers on a rising edge where in_valid & in_ready are both 1; the
  // producer may drop in_valid at any time, and in_ready never depends on in_valid.
  modport master (
    output clr, in_valid, in_act, w_bus, bias_bus,
    input  in_ready, layer_out, valid
  );
  modport slave (
    input  clr, in_valid, in_act, w_bus, bias_bus,
    output in_ready, layer_out, valid
  );
endinterface

// File: rtl/fc_output_accumulator.sv
// Output fully-connected stage: 10 signed MAC sums over N_IN activations, then bias,
// then a one-cycle valid pulse. Define FC_ACC_SAT_EN for sticky saturating adds.
`timescale 1ns/1ps
module fc_output_accumulator #(
  parameter int N_IN  = 64,
  parameter int IN_W  = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 30
) (
  input  logic                   clk,
  input  logic                   rst,
  fc_output_accumulator_if.slave bus,
  output logic [1:0]             dbg_state
);
  localparam int NN    = 10;
  localparam int PW    = 2 * IN_W;
  localparam int CNT_W = $clog2(N_IN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BIAS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc     [NN];
  logic signed [ACC_W-1:0] acc_nxt [NN];
  logic signed [ACC_W-1:0] add_op  [NN];
  logic signed [PW-1:0]    prod    [NN];
  logic signed [PW-1:0]    act_ext;
  logic [NN*ACC_W-1:0]     layer_q;
  logic                    valid_q;
  logic                    take;

  assign bus.in_ready  = ((state == IDLE) || (state == ACCUM)) && !bus.clr;
  assign take          = bus.in_valid && bus.in_ready;
  assign bus.layer_out = layer_q;
  assign bus.valid     = valid_q;
  assign dbg_state     = state;

  assign act_ext = PW'($signed(bus.in_act));

  // The same adder serves the beat products and the bias add in BIAS.
  always_comb begin
    for (int k = 0; k < NN; k++) begin
      prod[k]   = act_ext * PW'($signed(bus.w_bus[IN_W*k +: IN_W]));
      add_op[k] = (state == BIAS) ? ACC_W'($signed(bus.bias_bus[B_W*k +: B_W]))
                                  : ACC_W'(prod[k]);
    end
  end

`ifdef FC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [NN-1:0]   sat_q;
  logic [NN-1:0]   sat_nxt;
  logic [ACC_W:0]  sum_w [NN];

  // Once a neuron clamps it holds the rail until the next frame overwrites it.
  always_comb begin
    for (int k = 0; k < NN; k++) begin
      sum_w[k]   = {acc[k][ACC_W-1], acc[k]} + {add_op[k][ACC_W-1], add_op[k]};
      sat_nxt[k] = sat_q[k];
      acc_nxt[k] = sum_w[k][ACC_W-1:0];
      if (sat_q[k]) begin
        acc_nxt[k] = acc[k];
      end else if (sum_w[k][ACC_W] != sum_w[k][ACC_W-1]) begin
        sat_nxt[k] = 1'b1;
        acc_nxt[k] = sum_w[k][ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end
  end
`else
  always_comb begin
    for (int k = 0; k < NN; k++) begin
      acc_nxt[k] = acc[k] + add_op[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      layer_q <= '0;
      for (int k = 0; k < NN; k++) acc[k] <= '0;
`ifdef FC_ACC_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (bus.clr) begin
        // layer_q is deliberately kept so the argmax stage still sees the last result
        state <= IDLE;
        cnt   <= '0;
        for (int k = 0; k < NN; k++) acc[k] <= '0;
`ifdef FC_ACC_SAT_EN
        sat_q <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (take) begin
              for (int k = 0; k < NN; k++) acc[k] <= ACC_W'(prod[k]);
              cnt   <= CNT_W'(1);
              state <= ACCUM;
`ifdef FC_ACC_SAT_EN
              sat_q <= '0;
`endif
            end
          end
          ACCUM: begin
            if (take) begin
              for (int k = 0; k < NN; k++) acc[k] <= acc_nxt[k];
              cnt <= cnt + 1'b1;
              if (cnt == CNT_W'(N_IN - 1)) state <= BIAS;
`ifdef FC_ACC_SAT_EN
              sat_q <= sat_nxt;
`endif
            end
          end
          BIAS: begin
            for (int k = 0; k < NN; k++) acc[k] <= acc_nxt[k];
            state <= DONE;
`ifdef FC_ACC_SAT_EN
            sat_q <= sat_nxt;
`endif
          end
          DONE: begin
            for (int k = 0; k < NN; k++) layer_q[ACC_W*k +: ACC_W] <= acc[k];
            valid_q <= 1'b1;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fc_output_accumulator.sv
// Self-checking bench for fc_output_accumulator: random and directed frames on an
// N_IN=4 instance against a behavioural model, plus an N_IN=8/ACC_W=18 overflow instance.
`timescale 1ns/1ps
module tb_fc_output_accumulator;
  localparam int IN_W  = 8;
  localparam int B_W   = 16;
  localparam int A_N   = 4;
  localparam int A_ACC = 30;
  localparam int B_N   = 8;
  localparam int B_ACC = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  fc_output_accumulator_if #(.IN_W(IN_W), .B_W(B_W), .ACC_W(A_ACC)) a_if ();
  fc_output_accumulator_if #(.IN_W(IN_W), .B_W(B_W), .ACC_W(B_ACC)) b_if ();
  logic [1:0] a_dbg;
  logic [1:0] b_dbg;

  fc_output_accumulator #(.N_IN(A_N), .IN_W(IN_W), .B_W(B_W), .ACC_W(A_ACC)) u_a (
    .clk(clk), .rst(rst), .bus(a_if), .dbg_state(a_dbg));
  fc_output_accumulator #(.N_IN(B_N), .IN_W(IN_W), .B_W(B_W), .ACC_W(B_ACC)) u_b (
    .clk(clk), .rst(rst), .bus(b_if), .dbg_state(b_dbg));

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint model_add(input longint a, input longint b, input int w,
                                       inout bit s);
    longint r;
    longint hi;
    r  = a + b;
    hi = (longint'(1) <<< (w - 1)) - 1;
`ifdef FC_ACC_SAT_EN
    if (s) return a;
    if (r > hi) begin s = 1'b1; return hi; end
    if (r < -hi - 1) begin s = 1'b1; return -hi - 1; end
    return r;
`else
    s = 1'b0;
    r = r & ((longint'(1) <<< w) - 1);
    if (r > hi) r = r - (longint'(1) <<< w);
    return r;
`endif
  endfunction

  longint m_acc [10];
  bit     m_sat [10];
  int     m_cnt = 0;
  int     stall = 0;
  int     a_w    [10];
  int     a_bias [10];

  logic [10*A_ACC-1:0] exp_q [$];
  int                  due_q [$];
  logic [10*A_ACC-1:0] hold_exp = '0;
  int                  pulse_q [$];

  // ---------------- driver for instance A ----------------
  task automatic a_cycle(input bit v, input int act, input bit c);
    bit rdy_exp;
    logic [10*A_ACC-1:0] p;
    @(negedge clk);
    a_if.in_valid = v;
    a_if.clr      = c;
    a_if.in_act   = IN_W'(act);
    for (int k = 0; k < 10; k++) begin
      a_if.w_bus[IN_W*k +: IN_W]  = IN_W'(a_w[k]);
      a_if.bias_bus[B_W*k +: B_W] = B_W'(a_bias[k]);
    end
    rdy_exp = (stall == 0) && !c;
    #1;
    chk("a_in_ready", a_if.in_ready, rdy_exp);
    if (stall > 0) stall--;
    if (c) begin
      m_cnt = 0;
    end else if (v && rdy_exp) begin
      for (int k = 0; k < 10; k++) begin
        if (m_cnt == 0) begin
          m_acc[k] = longint'(act) * longint'(a_w[k]);
          m_sat[k] = 1'b0;
        end else begin
          m_acc[k] = model_add(m_acc[k], longint'(act) * longint'(a_w[k]), A_ACC, m_sat[k]);
        end
      end
      m_cnt++;
      if (m_cnt == A_N) begin
        for (int k = 0; k < 10; k++) begin
          m_acc[k] = model_add(m_acc[k], longint'(a_bias[k]), A_ACC, m_sat[k]);
          p[A_ACC*k +: A_ACC] = A_ACC'(m_acc[k]);
        end
        exp_q.push_back(p);
        due_q.push_back(cyc + 3);
        stall = 2;
        m_cnt = 0;
      end
    end
  endtask

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) a_cycle(1'b0, 0, 1'b0);
  endtask

  task automatic a_rand_frame_data();
    for (int k = 0; k < 10; k++) a_bias[k] = int'($urandom_range(65535)) - 32768;
  endtask

  task automatic a_rand_weights();
    for (int k = 0; k < 10; k++) a_w[k] = int'($urandom_range(255)) - 128;
  endtask

  // ---------------- compare process ----------------
  initial begin : compare
    bit v_exp;
    forever begin
      @(posedge clk);
      #3;
      v_exp = (due_q.size() > 0) && (due_q[0] == cyc);
      if (v_exp) begin
        hold_exp = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      if (a_if.valid === 1'b1) pulse_q.push_back(cyc);
      chk("a_valid", a_if.valid, v_exp);
      chk("a_layer_out", a_if.layer_out, hold_exp);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int fa_act [A_N];
    int fa_w   [A_N][10];
    longint b_m;
    bit     b_s;
    longint b_lit;
    int     waited;
    bit     got;

    a_if.clr = 0; a_if.in_valid = 0; a_if.in_act = '0; a_if.w_bus = '0; a_if.bias_bus = '0;
    b_if.clr = 0; b_if.in_valid = 0; b_if.in_act = '0; b_if.w_bus = '0; b_if.bias_bus = '0;
    for (int k = 0; k < 10; k++) begin a_w[k] = 0; a_bias[k] = 0; end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_in_ready", a_if.in_ready, 1'b1);
    chk("reset_layer_out", a_if.layer_out, '0);
    chk("reset_valid", a_if.valid, 1'b0);

    // basic frame: act 1, w[k]=k, bias 0 -> word k = 4k
    for (int k = 0; k < 10; k++) begin a_w[k] = k; a_bias[k] = 0; end
    for (int i = 0; i < A_N; i++) a_cycle(1'b1, 1, 1'b0);
    a_idle(4);
    for (int k = 0; k < 10; k++)
      chk($sformatf("basic_word%0d", k), a_if.layer_out[A_ACC*k +: A_ACC], 30'(4 * k));

    // signed math and bias: -3*5*4 - 100 = -160
    for (int k = 0; k < 10; k++) begin a_w[k] = 5; a_bias[k] = -100; end
    for (int i = 0; i < A_N; i++) a_cycle(1'b1, -3, 1'b0);
    a_idle(4);
    chk("signed_word0", a_if.layer_out[0 +: A_ACC], 30'h3FFFFF60);
    chk("signed_word9", a_if.layer_out[A_ACC*9 +: A_ACC], 30'h3FFFFF60);

    // frame A: same data back-to-back, then with random bubbles carrying junk
    a_rand_frame_data();
    for (int i = 0; i < A_N; i++) begin
      fa_act[i] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < 10; k++) fa_w[i][k] = int'($urandom_range(255)) - 128;
    end
    for (int i = 0; i < A_N; i++) begin
      for (int k = 0; k < 10; k++) a_w[k] = fa_w[i][k];
      a_cycle(1'b1, fa_act[i], 1'b0);
    end
    a_idle(3);
    for (int i = 0; i < A_N; i++) begin
      int gaps;
      gaps = int'($urandom_range(3));
      for (int g = 0; g < gaps; g++) begin
        a_rand_weights();
        a_cycle(1'b0, int'($urandom_range(255)), 1'b0);
      end
      for (int k = 0; k < 10; k++) a_w[k] = fa_w[i][k];
      a_cycle(1'b1, fa_act[i], 1'b0);
    end
    a_idle(3);

    // frame B: clr after 2 beats (with a beat offered), then a full new frame
    a_rand_frame_data();
    for (int i = 0; i < 2; i++) begin a_rand_weights(); a_cycle(1'b1, int'($urandom_range(255)) - 128, 1'b0); end
    a_rand_weights();
    a_cycle(1'b1, 77, 1'b1);
    for (int i = 0; i < A_N; i++) begin a_rand_weights(); a_cycle(1'b1, int'($urandom_range(255)) - 128, 1'b0); end
    a_idle(4);

    // mid-frame reset after 2 beats
    a_rand_frame_data();
    for (int i = 0; i < 2; i++) begin a_rand_weights(); a_cycle(1'b1, int'($urandom_range(255)) - 128, 1'b0); end
    @(negedge clk);
    a_if.in_valid = 1'b0;
    m_cnt = 0; stall = 0; exp_q.delete(); due_q.delete(); hold_exp = '0;
    rst = 1'b0;
    #1;
    chk("midrst_layer_out", a_if.layer_out, '0);
    chk("midrst_valid", a_if.valid, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < A_N; i++) begin a_rand_weights(); a_cycle(1'b1, int'($urandom_range(255)) - 128, 1'b0); end
    a_idle(4);

    // three back-to-back frames with in_valid held high
    pulse_q.delete();
    for (int i = 0; i < 3 * (A_N + 2); i++) begin
      if (m_cnt == 0 && stall == 0) a_rand_frame_data();
      a_rand_weights();
      a_cycle(1'b1, int'($urandom_range(255)) - 128, 1'b0);
    end
    a_idle(4);
    chk("b2b_pulse_count", pulse_q.size(), 3);
    if (pulse_q.size() >= 3) begin
      chk("b2b_gap1", pulse_q[1] - pulse_q[0], A_N + 2);
      chk("b2b_gap2", pulse_q[2] - pulse_q[1], A_N + 2);
    end

    // overflow on the ACC_W=18 instance: 8 x 16384 = 131072
    b_m = 0; b_s = 1'b0;
    for (int i = 0; i < B_N; i++) begin
      @(negedge clk);
      b_if.in_valid = 1'b1;
      b_if.in_act   = 8'h80;
      for (int k = 0; k < 10; k++) b_if.w_bus[IN_W*k +: IN_W] = 8'h80;
      b_if.bias_bus = '0;
      #1;
      chk("b_in_ready", b_if.in_ready, 1'b1);
      b_m = (i == 0) ? 64'sd16384 : model_add(b_m, 64'sd16384, B_ACC, b_s);
    end
    b_m = model_add(b_m, 64'sd0, B_ACC, b_s);
    @(negedge clk);
    b_if.in_valid = 1'b0;
`ifdef FC_ACC_SAT_EN
    b_lit = 131071;
`else
    b_lit = -131072;
`endif
    chk("b_model_pin", b_m[B_ACC-1:0], b_lit[B_ACC-1:0]);
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      @(posedge clk);
      #3;
      if (b_if.valid === 1'b1) got = 1'b1;
      waited++;
    end
    chk("b_valid_seen", got, 1'b1);
    for (int k = 0; k < 10; k++)
      chk($sformatf("b_word%0d", k), b_if.layer_out[B_ACC*k +: B_ACC], b_lit[B_ACC-1:0]);

    a_idle(2);
    chk("a_pending_frames", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
